instruction_loader: RTL and testbench

Writes a program image into the instruction memory's write port from a byte stream delivered by the UART receiver, so the fetch stage can later read it. Holds the CPU (forces PC writes off and keeps the pipeline stalled) for the whole load. Reports completion or a framing/checksum error. Sits between the debug UART receiver and port B of the instruction memory.

---
 rtl/instruction_loader_pkg.sv | 20 ++
 rtl/instruction_loader_word_assembler.sv | 62 ++++++
 rtl/instruction_loader.sv | 147 ++++++++++++++
 tb/tb_instruction_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared states, frame constants and word sizing for the instruction loader
package instruction_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int CSUM_BYTES = 1;

   function automatic int BYTES_PER_WORD(input int width_b);
      return width_b / 8;
   endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// rtl/instruction_loader_word_assembler.sv - packs MSB-first bytes into words with a one-cycle word_valid strobe
module word_assembler
   import instruction_loader_pkg::*;
#(
   parameter int width_B = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               last_byte,
   output logic               word_valid,
   output logic [width_B-1:0] word
);

   localparam logic [7:0] LAST_IDX = 8'(BYTES_PER_WORD(width_B) - 1);

   logic [width_B-1:0] shift_q, shift_d;
   logic [width_B-1:0] word_q, word_d;
   logic [7:0]         idx_q, idx_d;
   logic               word_valid_q, word_valid_d;

   always_comb begin
      shift_d      = shift_q;
      idx_d        = idx_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      last_byte    = byte_valid && (idx_q == LAST_IDX);
      if (clear) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (byte_valid) begin
         shift_d = {shift_q[width_B-9:0], byte_data};
         if (idx_q == LAST_IDX) begin
            word_d       = {shift_q[width_B-9:0], byte_data};
            word_valid_d = 1'b1;
            idx_d        = '0;
         end else begin
            idx_d = idx_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q      <= '0;
         idx_q        <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word_valid = word_valid_q;
   assign word       = word_q;

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads a length/data/checksum UART frame into instruction memory port B
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int width_B = 32,
   parameter int Addr_B  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               mem_we,
   output logic [Addr_B-1:0]  mem_addr,
   output logic [width_B-1:0] mem_wdata,
   output logic               busy,
   output logic               cpu_hold,
   output logic               done,
   output logic               error
);

   localparam logic [31:0] MAX_WORDS = 32'd1 << Addr_B;

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [7:0]        csum_q, csum_d;
   logic [Addr_B:0]   addr_q, addr_d;
   logic [Addr_B-1:0] mem_addr_q, mem_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              asm_clear, asm_valid, asm_last;
   logic [31:0]       next_count, len_lo_words;

   assign asm_clear    = (state_q == ST_IDLE) && start;
   assign asm_valid    = (state_q == ST_DATA) && rx_valid;
   assign next_count   = 32'(addr_q) + 32'd1;
   assign len_lo_words = {16'd0, len_q[15:8], rx_data};

   word_assembler #(.width_B(width_B)) u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (asm_clear),
      .byte_valid (asm_valid),
      .byte_data  (rx_data),
      .last_byte  (asm_last),
      .word_valid (mem_we),
      .word       (mem_wdata)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      mem_addr_d = mem_addr_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      unique case (state_q)
         ST_IDLE: begin
            // A byte arriving with start is dropped: the frame begins on the next byte.
            if (start) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               csum_d  = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (rx_valid) begin
               len_d   = {rx_data, 8'h00};
               csum_d  = csum_q ^ rx_data;
               state_d = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (rx_valid) begin
               len_d  = len_lo_words[15:0];
               csum_d = csum_q ^ rx_data;
               if (len_lo_words > MAX_WORDS) begin
                  error_d = 1'b1;
                  state_d = ST_FINISH;
               end else if (len_lo_words == 32'd0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               csum_d = csum_q ^ rx_data;
               if (asm_last) begin
                  mem_addr_d = addr_q[Addr_B-1:0];
                  addr_d     = addr_q + 1'b1;
                  if (next_count == {16'd0, len_q}) state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (rx_valid) begin
               if (rx_data == csum_q) done_d = 1'b1;
               else                   error_d = 1'b1;
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign cpu_hold = busy_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        busy, cpu_hold, done, error;

   int tests  = 0;
   int failed = 0;

   logic [9:0]  wr_addr [16];
   logic [31:0] wr_data [16];
   int          wr_cnt = 0;

   instruction_loader #(.width_B(32), .Addr_B(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Write log: mem_we lasts one full cycle, so each write is seen once here.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (wr_cnt < 16) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests = tests + 1;
      assert (obs === exp)
      else begin
         failed = failed + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_we"},    64'(mem_we),    64'd0);
      chk({tag, "_addr"},  64'(mem_addr),  64'd0);
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, "_busy"},  64'(busy),      64'd0);
      chk({tag, "_hold"},  64'(cpu_hold),  64'd0);
      chk({tag, "_done"},  64'(done),      64'd0);
      chk({tag, "_err"},   64'(error),     64'd0);
   endtask

   initial begin
      int base;
      rst_n    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Good two-word frame, bytes back-to-back.
      pulse_start();
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_hold", 64'(cpu_hold), 64'd1);
      send(8'h00); send(8'h02);
      send(8'h20); send(8'h01); send(8'h00); send(8'h05);
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      send(8'h26);
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_err", 64'(error), 64'd0);
      chk("t1_busy_t", 64'(busy), 64'd1);
      @(negedge clk);
      chk("t1_busy_end", 64'(busy), 64'd0);
      chk("t1_wr_cnt", 64'(wr_cnt), 64'd2);
      chk("t1_a0", 64'(wr_addr[0]), 64'd0);
      chk("t1_d0", 64'(wr_data[0]), 64'h2001_0005);
      chk("t1_a1", 64'(wr_addr[1]), 64'd1);
      chk("t1_d1", 64'(wr_data[1]), 64'h0000_0000);

      // Same frame, bad checksum: words still written.
      pulse_start();
      chk("t2_done_clr", 64'(done), 64'd0);
      send(8'h00); send(8'h02);
      send(8'h20); send(8'h01); send(8'h00); send(8'h05);
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      send(8'h27);
      chk("t2_err", 64'(error), 64'd1);
      chk("t2_done", 64'(done), 64'd0);
      @(negedge clk);
      chk("t2_busy_end", 64'(busy), 64'd0);
      chk("t2_wr_cnt", 64'(wr_cnt), 64'd4);
      chk("t2_a3", 64'(wr_addr[3]), 64'd1);
      chk("t2_d2", 64'(wr_data[2]), 64'h2001_0005);

      // Length one past capacity.
      pulse_start();
      chk("t3_err_clr", 64'(error), 64'd0);
      send(8'h04); send(8'h01);
      chk("t3_err", 64'(error), 64'd1);
      chk("t3_busy_t", 64'(busy), 64'd1);
      @(negedge clk);
      chk("t3_busy_end", 64'(busy), 64'd0);
      chk("t3_done", 64'(done), 64'd0);
      chk("t3_wr_cnt", 64'(wr_cnt), 64'd4);

      // Length exactly at capacity is accepted, then aborted by reset.
      pulse_start();
      send(8'h04); send(8'h00);
      chk("t3b_err", 64'(error), 64'd0);
      chk("t3b_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t3b_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty frame.
      pulse_start();
      send(8'h00); send(8'h00); send(8'h00);
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_err", 64'(error), 64'd0);
      @(negedge clk);
      chk("t4_busy_end", 64'(busy), 64'd0);
      chk("t4_wr_cnt", 64'(wr_cnt), 64'd4);

      // Reset in the middle of word 1.
      pulse_start();
      send(8'h00); send(8'h02);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h55); send(8'h66);
      chk("t5_wr_cnt_pre", 64'(wr_cnt), 64'd5);
      chk("t5_d4", 64'(wr_data[4]), 64'h1122_3344);
      #1;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("t5_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_wr_cnt_post", 64'(wr_cnt), 64'd5);
      pulse_start();
      send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      send(8'h23);
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_err", 64'(error), 64'd0);
      @(negedge clk);
      chk("t5_wr_cnt", 64'(wr_cnt), 64'd6);
      chk("t5_a5", 64'(wr_addr[5]), 64'd0);
      chk("t5_d5", 64'(wr_data[5]), 64'hDEAD_BEEF);

      // Stray idle bytes, start with a byte, and start while busy are all ignored.
      send(8'hAA); send(8'hBB);
      chk("t6_idle_busy", 64'(busy), 64'd0);
      chk("t6_idle_done", 64'(done), 64'd1);
      start    = 1'b1;
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      chk("t6_busy", 64'(busy), 64'd1);
      chk("t6_done_clr", 64'(done), 64'd0);
      send(8'h00); send(8'h01);
      pulse_start();
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      send(8'h09);
      chk("t6_done", 64'(done), 64'd1);
      chk("t6_err", 64'(error), 64'd0);
      @(negedge clk);
      chk("t6_busy_end", 64'(busy), 64'd0);
      base = 6;
      chk("t6_wr_cnt", 64'(wr_cnt), 64'd7);
      chk("t6_a", 64'(wr_addr[base]), 64'd0);
      chk("t6_d", 64'(wr_data[base]), 64'h1234_5678);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
